// File: rtl/semaforo_ctrl.sv
// semaforo_ctrl
// Three-light traffic-signal controller.
//   Automatic mode (mainageability = 0): cycles GREEN -> YELLOW -> RED -> GREEN,
//   dwelling GREEN_CYCLES / YELLOW_CYCLES / RED_CYCLES clock periods per colour.
//   Manual mode (mainageability = 1): lamps follow the registered operator
//   override inputs.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   mainageability mode select: 1 = manual/maintenance, 0 = automatic
//   green_m        manual green request
//   yellow_m       manual yellow request
//   red_m          manual red request
//   green_led      green lamp, active high
//   yellow_led     yellow lamp, active high
//   red_led        red lamp, active high
module semaforo_ctrl #(
  parameter int GREEN_CYCLES  = 5,
  parameter int YELLOW_CYCLES = 2,
  parameter int RED_CYCLES    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mainageability,
  input  logic green_m,
  input  logic yellow_m,
  input  logic red_m,
  output logic green_led,
  output logic yellow_led,
  output logic red_led
);

  localparam int MAX_CYCLES =
    (GREEN_CYCLES >= YELLOW_CYCLES && GREEN_CYCLES >= RED_CYCLES) ? GREEN_CYCLES :
    (YELLOW_CYCLES >= RED_CYCLES) ? YELLOW_CYCLES : RED_CYCLES;

  // A dwell of 1 everywhere still needs a 1-bit counter
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic [2:0]       man_q;
  logic [CNT_W-1:0] dwell_last;

  // Last count value of the colour currently lit
  always_comb begin
    dwell_last = GREEN_LAST;
    case (state)
      GREEN:   dwell_last = GREEN_LAST;
      YELLOW:  dwell_last = YELLOW_LAST;
      RED:     dwell_last = RED_LAST;
      default: dwell_last = GREEN_LAST;
    endcase
  end

  // The FSM is held at GREEN both on the edge that enters manual mode and on
  // the edge that leaves it (mode_q still 1), so a fresh green dwell always
  // starts exactly at the edge that samples mainageability = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= GREEN;
      cnt    <= '0;
      mode_q <= 1'b0;
      man_q  <= 3'b000;
    end else begin
      mode_q <= mainageability;
      man_q  <= {green_m, yellow_m, red_m};
      if (mainageability || mode_q) begin
        state <= GREEN;
        cnt   <= '0;
      end else if (cnt == dwell_last) begin
        cnt <= '0;
        case (state)
          GREEN:   state <= YELLOW;
          YELLOW:  state <= RED;
          RED:     state <= GREEN;
          default: state <= GREEN;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Lamps depend on registers only, so input changes never reach the lamps
  // without passing through a flop
  always_comb begin
    {green_led, yellow_led, red_led} = 3'b100;
    if (mode_q) begin
      {green_led, yellow_led, red_led} = man_q;
    end else begin
      case (state)
        GREEN:   {green_led, yellow_led, red_led} = 3'b100;
        YELLOW:  {green_led, yellow_led, red_led} = 3'b010;
        RED:     {green_led, yellow_led, red_led} = 3'b001;
        default: {green_led, yellow_led, red_led} = 3'b100;
      endcase
    end
  end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// tb_semaforo_ctrl
// Directed bench for semaforo_ctrl: one instance with default dwell times and
// one with all dwells set to 1, sharing clock and reset.
module tb_semaforo_ctrl;

  logic clk;
  logic rst_n;
  logic mainageability;
  logic green_m, yellow_m, red_m;
  logic green_led, yellow_led, red_led;
  logic green_led2, yellow_led2, red_led2;
  logic [2:0] leds;
  logic [2:0] leds2;

  int checks = 0;
  int errors = 0;
  int e2 = 0;

  assign leds  = {green_led, yellow_led, red_led};
  assign leds2 = {green_led2, yellow_led2, red_led2};

  semaforo_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mainageability (mainageability),
    .green_m        (green_m),
    .yellow_m       (yellow_m),
    .red_m          (red_m),
    .green_led      (green_led),
    .yellow_led     (yellow_led),
    .red_led        (red_led)
  );

  semaforo_ctrl #(
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1),
    .RED_CYCLES    (1)
  ) dut_fast (
    .clk            (clk),
    .rst_n          (rst_n),
    .mainageability (1'b0),
    .green_m        (1'b0),
    .yellow_m       (1'b0),
    .red_m          (1'b0),
    .green_led      (green_led2),
    .yellow_led     (yellow_led2),
    .red_led        (red_led2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lamps k edges after a fresh green start, defaults 5/2/5
  function automatic logic [2:0] autoLeds(input int k);
    int m;
    m = k % 12;
    if (m < 5)      return 3'b100;
    else if (m < 7) return 3'b010;
    else            return 3'b001;
  endfunction

  // Expected lamps for the 1/1/1 instance
  function automatic logic [2:0] fastLeds(input int k);
    case (k % 3)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic mode, input logic g, input logic y, input logic r);
    mainageability = mode;
    green_m  = g;
    yellow_m = y;
    red_m    = r;
  endtask

  // One clock edge, then sample 1 time unit later and check the fast instance
  task automatic stepCycle();
    @(posedge clk);
    #1;
    e2++;
    checkOutput("fast_rotate", leds2, fastLeds(e2));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("reset", leds, 3'b100);
    checkOutput("reset_fast", leds2, 3'b100);

    @(negedge clk);
    rst_n = 1'b1;
    e2 = 0;
    checkOutput("auto_k0", leds, autoLeds(0));

    // Automatic cycle: 100 x5, 010 x2, 001 x5, then 100 again
    for (int k = 1; k <= 15; k++) begin
      stepCycle();
      checkOutput("auto_cycle", leds, autoLeds(k));
    end

    // Enter manual with all overrides on
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("manual_111", leds, 3'b111);
    end

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("manual_010", leds, 3'b010);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    stepCycle();
    checkOutput("manual_001", leds, 3'b001);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("manual_000", leds, 3'b000);

    // Leave manual: fresh green dwell from the exit edge, run into red
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("exit_k0", leds, autoLeds(0));
    for (int k = 1; k <= 8; k++) begin
      stepCycle();
      checkOutput("exit_cycle", leds, autoLeds(k));
    end

    // One-cycle manual pulse while in red, then green restarts;
    // overrides held high afterwards must be ignored in automatic mode
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    stepCycle();
    checkOutput("pulse_101", leds, 3'b101);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    stepCycle();
    checkOutput("pulse_k0", leds, autoLeds(0));
    for (int k = 1; k <= 17; k++) begin
      stepCycle();
      checkOutput("from_red_cycle", leds, autoLeds(k));
    end

    // Now mid-yellow; assert reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", leds, 3'b100);
    checkOutput("async_reset_fast", leds2, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    e2 = 0;
    checkOutput("rerun_k0", leds, autoLeds(0));
    for (int k = 1; k <= 6; k++) begin
      stepCycle();
      checkOutput("rerun_cycle", leds, autoLeds(k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
